// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, occupancy and status-flag controller that sits
// in front of memory_array to form the synchronous FIFO.
module fifo_ptr_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int THRESHOLD  = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  fifo_we,
    output logic                  fifo_rd,
    output logic [ADDR_WIDTH-1:0] wptr,
    output logic [ADDR_WIDTH-1:0] rptr,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_threshold,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = PW'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] L_THR   = PW'(THRESHOLD);

    logic [ADDR_WIDTH:0] r_wp;
    logic [ADDR_WIDTH:0] r_rp;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_thr;
    logic                r_ovf;
    logic                r_udf;

    logic                w_we;
    logic                w_rd;
    logic [ADDR_WIDTH:0] w_wp_nxt;
    logic [ADDR_WIDTH:0] w_rp_nxt;
    logic [ADDR_WIDTH:0] w_cnt_nxt;
    logic                w_ovf_nxt;
    logic                w_udf_nxt;

    // Accept logic and next-state pointers; reset masks both strobes so
    // nothing reaches the memory while the controller is being cleared.
    always_comb begin
        w_we      = wr & ~r_full & ~rst;
        w_rd      = rd & ~r_empty & ~rst;
        w_wp_nxt  = r_wp + PW'(w_we);
        w_rp_nxt  = r_rp + PW'(w_rd);
        w_cnt_nxt = w_wp_nxt - w_rp_nxt;
        w_ovf_nxt = (wr & r_full) | (r_ovf & ~clr_err);
        w_udf_nxt = (rd & r_empty) | (r_udf & ~clr_err);
    end

    // Pointer, occupancy and flag registers; flags come from next-state
    // pointers so they are never a cycle stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_thr   <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_wp    <= w_wp_nxt;
            r_rp    <= w_rp_nxt;
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == L_DEPTH);
            r_empty <= (w_cnt_nxt == '0);
            r_thr   <= (w_cnt_nxt >= L_THR);
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
        end
    end

    assign fifo_we        = w_we;
    assign fifo_rd        = w_rd;
    assign wptr           = r_wp[ADDR_WIDTH-1:0];
    assign rptr           = r_rp[ADDR_WIDTH-1:0];
    assign count          = r_count;
    assign fifo_full      = r_full;
    assign fifo_empty     = r_empty;
    assign fifo_threshold = r_thr;
    assign fifo_overflow  = r_ovf;
    assign fifo_underflow = r_udf;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: directed plus random stimulus for fifo_ptr_ctrl,
// checked against a queue-based FIFO model and a bench-side memory.
module tb_fifo_ptr_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int THR   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          clr_err = 1'b0;
    logic          fifo_we;
    logic          fifo_rd;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_threshold;
    logic          fifo_overflow;
    logic          fifo_underflow;
    logic [AW:0]   count;

    fifo_ptr_ctrl #(.ADDR_WIDTH(AW), .THRESHOLD(THR)) dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .clr_err(clr_err),
        .fifo_we(fifo_we), .fifo_rd(fifo_rd),
        .wptr(wptr), .rptr(rptr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_threshold(fifo_threshold),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
        .count(count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    logic [31:0] q[$];
    int          wpos = 0;
    int          rpos = 0;
    bit          ovf_m = 0;
    bit          udf_m = 0;
    bit          known = 0;
    int          passed = 0;
    int          total = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(bit w, bit r, bit c, bit rs, logic [31:0] din);
        bit full_m;
        bit empty_m;
        bit aw;
        bit ar;
        rst = rs;
        wr = w;
        rd = r;
        clr_err = c;
        #1;
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        aw = w && !full_m && !rs;
        ar = r && !empty_m && !rs;
        if (known) begin
            chk("fifo_we", {31'd0, fifo_we}, {31'd0, aw});
            chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, ar});
            if (ar) chk("data_out", mem[rptr], q[0]);
        end
        if (fifo_we === 1'b1) mem[wptr] = din;
        @(posedge clk);
        if (rs) begin
            q.delete();
            wpos = 0;
            rpos = 0;
            ovf_m = 0;
            udf_m = 0;
            known = 1;
        end else if (known) begin
            ovf_m = (w && full_m) || (ovf_m && !c);
            udf_m = (r && empty_m) || (udf_m && !c);
            if (ar) begin
                void'(q.pop_front());
                rpos = (rpos + 1) % DEPTH;
            end
            if (aw) begin
                q.push_back(din);
                wpos = (wpos + 1) % DEPTH;
            end
        end
        #1;
        if (known) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("wptr", 32'(wptr), 32'(wpos));
            chk("rptr", 32'(rptr), 32'(rpos));
            chk("full", {31'd0, fifo_full}, {31'd0, q.size() == DEPTH});
            chk("empty", {31'd0, fifo_empty}, {31'd0, q.size() == 0});
            chk("threshold", {31'd0, fifo_threshold},
                {31'd0, q.size() >= THR});
            chk("overflow", {31'd0, fifo_overflow}, {31'd0, ovf_m});
            chk("underflow", {31'd0, fifo_underflow}, {31'd0, udf_m});
        end
    endtask

    initial begin
        // reset with wr/rd held high
        step(1, 1, 0, 1, 32'h0);
        step(1, 1, 0, 1, 32'h0);
        // fill, overflow, hold, clear
        step(1, 0, 0, 0, 32'hAA55AA55);
        step(1, 0, 0, 0, 32'h55AA55AA);
        step(1, 0, 0, 0, 32'h1);
        step(1, 0, 0, 0, 32'h2);
        step(1, 0, 0, 0, 32'h3);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        // drain, underflow, clear
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        // simultaneous at count 2
        step(1, 0, 0, 0, 32'h10);
        step(1, 0, 0, 0, 32'h11);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, $urandom);
        // simultaneous at full
        step(1, 0, 0, 0, 32'h20);
        step(1, 0, 0, 0, 32'h21);
        step(1, 1, 0, 0, 32'h22);
        step(0, 0, 1, 0, 32'h0);
        // simultaneous at empty
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h30);
        step(0, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        // mid-operation reset
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h40 + 32'(i));
        step(0, 0, 0, 1, 32'h0);
        step(1, 0, 0, 0, 32'hCAFE0001);
        step(0, 1, 0, 0, 32'h0);
        // clear/set race on overflow
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h50 + 32'(i));
        step(1, 0, 1, 0, 32'h60);
        step(1, 0, 1, 0, 32'h61);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2,
                 $urandom);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
